// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side and multdiv-writeback signals of the decode stage.
// The decode stage connects to the slave modport and its environment connects to the master modport.
interface decode_stage_if #(
  parameter int INSN_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [INSN_W-1:0]     in_insn;
  logic [PC_W-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_W-1:0]       out_pc;
  logic [16:0]           out_imm;
  logic [26:0]           out_target;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [REG_ADDR_W-1:0] out_src_a;
  logic [REG_ADDR_W-1:0] out_src_b;
  logic [15:0]           out_ctrl;
  logic                  md_busy;
  logic                  md_wb_valid;
  logic [REG_ADDR_W-1:0] md_wb_rd;

  modport slave (
    input  flush, in_valid, in_insn, in_pc, out_ready, md_wb_valid, md_wb_rd,
    output in_ready, out_valid, out_pc, out_imm, out_target, out_rd,
           out_src_a, out_src_b, out_ctrl, md_busy
  );

  modport master (
    output flush, in_valid, in_insn, in_pc, out_ready, md_wb_valid, md_wb_rd,
    input  in_ready, out_valid, out_pc, out_imm, out_target, out_rd,
           out_src_a, out_src_b, out_ctrl, md_busy
  );
endinterface

// File: rtl/decode_stage.sv
// Registered decode stage with a mult/div scoreboard; DECODE_PERF_EN adds perf_issued/perf_stalls counters.
// Latency is 1 cycle. The output is held while out_ready=0, and input stalls on a scoreboard hazard or on a full stage.
module decode_stage #(
  parameter int INSN_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30
) (
  input  logic           clock,
  input  logic           resetn,
  decode_stage_if.slave  bus
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]    perf_issued,
  output logic [31:0]    perf_stalls
`endif
);
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam int CTRL_WE   = 11;
  localparam int CTRL_MULT = 10;
  localparam int CTRL_DIV  = 9;
  localparam logic [REG_ADDR_W-1:0] LINK_ADDR   = REG_ADDR_W'(LINK_REG);
  localparam logic [REG_ADDR_W-1:0] STATUS_ADDR = REG_ADDR_W'(STATUS_REG);

  logic [4:0]            opcode;
  logic [4:0]            aluop;
  logic [REG_ADDR_W-1:0] f_rd, f_rs, f_rt;
  logic is_r, is_addi, is_sw, is_lw, is_bne, is_blt, is_j, is_jal, is_jr, is_bex, is_setx;
  logic is_mult, is_div, dec_we, hazard, accept, xfer;
  logic [REG_ADDR_W-1:0] dec_rd, dec_src_a, dec_src_b;
  logic [15:0]           dec_ctrl;
  logic [2**REG_ADDR_W-1:0] sb;

  assign opcode = bus.in_insn[INSN_W-1 -: 5];
  assign f_rd   = bus.in_insn[INSN_W-6 -: REG_ADDR_W];
  assign f_rs   = bus.in_insn[INSN_W-6-REG_ADDR_W -: REG_ADDR_W];
  assign f_rt   = bus.in_insn[INSN_W-6-2*REG_ADDR_W -: REG_ADDR_W];
  assign aluop  = bus.in_insn[6:2];

  always_comb begin
    is_r = 1'b0; is_addi = 1'b0; is_sw = 1'b0; is_lw = 1'b0; is_bne = 1'b0; is_blt = 1'b0;
    is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_bex = 1'b0; is_setx = 1'b0;
    case (opcode)
      OP_R:    is_r    = 1'b1;
      OP_ADDI: is_addi = 1'b1;
      OP_SW:   is_sw   = 1'b1;
      OP_LW:   is_lw   = 1'b1;
      OP_BNE:  is_bne  = 1'b1;
      OP_BLT:  is_blt  = 1'b1;
      OP_J:    is_j    = 1'b1;
      OP_JAL:  is_jal  = 1'b1;
      OP_JR:   is_jr   = 1'b1;
      OP_BEX:  is_bex  = 1'b1;
      OP_SETX: is_setx = 1'b1;
      default: ;
    endcase
  end

  assign is_mult = is_r & (aluop == 5'b00110);
  assign is_div  = is_r & (aluop == 5'b00111);
  assign dec_rd  = is_jal ? LINK_ADDR : (is_setx ? STATUS_ADDR : f_rd);
  assign dec_we  = (is_r | is_addi | is_lw | is_jal | is_setx) & (dec_rd != '0);

  // j is also raised for jal so execute can treat both as the same unconditional redirect.
  assign dec_ctrl = {is_r, is_addi | is_sw | is_lw | is_bne | is_blt,
                     is_j | is_jal | is_bex | is_setx, is_jr, dec_we, is_mult, is_div,
                     is_bne, is_blt, is_lw, is_sw, is_jr, is_j | is_jal, is_jal, is_bex, is_setx};

  always_comb begin
    dec_src_a = '0;
    dec_src_b = '0;
    if (is_r | is_addi | is_lw | is_sw | is_bne | is_blt) dec_src_a = f_rs;
    else if (is_bex)                                      dec_src_a = STATUS_ADDR;
    if (is_r)                                             dec_src_b = f_rt;
    else if (is_sw | is_bne | is_blt | is_jr)             dec_src_b = f_rd;
  end

  // r0 never hazards. The scoreboard is read as registered, so a writeback releases the stall one cycle later.
  assign hazard = ((dec_src_a != '0) & sb[dec_src_a]) |
                  ((dec_src_b != '0) & sb[dec_src_b]) |
                  ((is_mult | is_div) & bus.md_busy);

  assign bus.in_ready = resetn & ~bus.flush & ~hazard & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign xfer         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid  <= 1'b0;
      bus.out_pc     <= '0;
      bus.out_imm    <= '0;
      bus.out_target <= '0;
      bus.out_rd     <= '0;
      bus.out_src_a  <= '0;
      bus.out_src_b  <= '0;
      bus.out_ctrl   <= '0;
    end else begin
      if (accept) begin
        bus.out_valid  <= 1'b1;
        bus.out_pc     <= bus.in_pc;
        bus.out_imm    <= bus.in_insn[16:0];
        bus.out_target <= bus.in_insn[26:0];
        bus.out_rd     <= dec_rd;
        bus.out_src_a  <= dec_src_a;
        bus.out_src_b  <= dec_src_b;
        bus.out_ctrl   <= dec_ctrl;
      end else if (xfer || bus.flush) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end

  // A flush does not stop a transfer that is already completing, so the scoreboard still tracks it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sb          <= '0;
      bus.md_busy <= 1'b0;
    end else if (bus.md_wb_valid) begin
      sb[bus.md_wb_rd] <= 1'b0;
      bus.md_busy      <= 1'b0;
    end else if (xfer && bus.out_ctrl[CTRL_WE] && (bus.out_ctrl[CTRL_MULT] || bus.out_ctrl[CTRL_DIV])) begin
      sb[bus.out_rd] <= 1'b1;
      bus.md_busy    <= 1'b1;
    end
  end

`ifdef DECODE_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_issued <= '0;
      perf_stalls <= '0;
    end else begin
      if (xfer)                   perf_issued <= perf_issued + 32'd1;
      if (bus.in_valid && hazard) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode rewrites, operand map, multdiv hazard, backpressure, flush and async reset.
module tb_decode_stage;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  decode_stage_if #(.INSN_W(32), .PC_W(32), .REG_ADDR_W(5)) bus ();

`ifdef DECODE_PERF_EN
  logic [31:0] perf_issued, perf_stalls;
  decode_stage dut (.clock(clock), .resetn(resetn), .bus(bus),
                    .perf_issued(perf_issued), .perf_stalls(perf_stalls));
`else
  decode_stage dut (.clock(clock), .resetn(resetn), .bus(bus));
`endif

  always #5 clock = ~clock;

  function automatic logic [31:0] r_insn(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] insn);
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b want 0", bus.md_busy); end
    n_tests++; if (bus.out_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0000", bus.out_ctrl); end
    tick();
    tick();
    resetn = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_jal();
    bus.in_pc = 32'h40;
    send(32'h18000064);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL jal_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.out_rd !== 5'd31) begin n_fail++; $display("FAIL jal_rd: got %0d want 31", bus.out_rd); end
    n_tests++; if (bus.out_ctrl !== 16'h280C) begin n_fail++; $display("FAIL jal_ctrl: got %h want 280c", bus.out_ctrl); end
    n_tests++; if (bus.out_target !== 27'd100) begin n_fail++; $display("FAIL jal_target: got %0d want 100", bus.out_target); end
    n_tests++; if (bus.out_pc !== 32'h40) begin n_fail++; $display("FAIL jal_pc: got %h want 40", bus.out_pc); end
    n_tests++; if ({bus.out_src_a, bus.out_src_b} !== 10'd0) begin n_fail++; $display("FAIL jal_srcs: got %0d/%0d want 0/0", bus.out_src_a, bus.out_src_b); end
  endtask

  task automatic test_setx_bex();
    send(32'hA8000005);
    n_tests++; if (bus.out_rd !== 5'd30) begin n_fail++; $display("FAIL setx_rd: got %0d want 30", bus.out_rd); end
    n_tests++; if (bus.out_ctrl !== 16'h2801) begin n_fail++; $display("FAIL setx_ctrl: got %h want 2801", bus.out_ctrl); end
    send(32'hB0000000);
    n_tests++; if (bus.out_src_a !== 5'd30) begin n_fail++; $display("FAIL bex_src_a: got %0d want 30", bus.out_src_a); end
    n_tests++; if (bus.out_ctrl !== 16'h2002) begin n_fail++; $display("FAIL bex_ctrl: got %h want 2002", bus.out_ctrl); end
  endtask

  task automatic test_r0_write();
    send(r_insn(5'd0, 5'd1, 5'd2, 5'd0));
    n_tests++; if (bus.out_ctrl !== 16'h8000) begin n_fail++; $display("FAIL add_r0_ctrl: got %h want 8000", bus.out_ctrl); end
    n_tests++; if ({bus.out_src_a, bus.out_src_b} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL add_r0_srcs: got %0d/%0d want 1/2", bus.out_src_a, bus.out_src_b); end
  endtask

  task automatic test_multdiv_hazard();
    send(r_insn(5'd4, 5'd2, 5'd3, 5'b00110));
    n_tests++; if (bus.out_ctrl !== 16'h8C00) begin n_fail++; $display("FAIL mult_ctrl: got %h want 8c00", bus.out_ctrl); end
    n_tests++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_early: got %b want 0", bus.md_busy); end
    tick();
    n_tests++; if (bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b want 1", bus.md_busy); end
    bus.in_valid = 1'b1;
    bus.in_insn  = r_insn(5'd5, 5'd4, 5'd1, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d: got %b want 0", i, bus.in_ready); end
      tick();
    end
    bus.in_insn = r_insn(5'd6, 5'd7, 5'd8, 5'b00110);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mult2_stall: got %b want 0", bus.in_ready); end
    bus.in_insn     = r_insn(5'd5, 5'd4, 5'd1, 5'd0);
    bus.md_wb_valid = 1'b1;
    bus.md_wb_rd    = 5'd4;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got %b want 0", bus.in_ready); end
    tick();
    bus.md_wb_valid = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", bus.in_ready); end
    n_tests++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b want 0", bus.md_busy); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_ctrl !== 16'h8800 || bus.out_rd !== 5'd5) begin n_fail++; $display("FAIL add_after_wb: got ctrl %h rd %0d want 8800 rd 5", bus.out_ctrl, bus.out_rd); end
    n_tests++; if ({bus.out_src_a, bus.out_src_b} !== {5'd4, 5'd1}) begin n_fail++; $display("FAIL add_after_wb_srcs: got %0d/%0d want 4/1", bus.out_src_a, bus.out_src_b); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(i_insn(5'b00101, 5'd1, 5'd2, 17'd7));
    bus.in_valid = 1'b1;
    bus.in_insn  = i_insn(5'b00101, 5'd3, 5'd2, 17'd9);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd1 || bus.out_imm !== 17'd7 || bus.out_ctrl !== 16'h4800)
        begin n_fail++; $display("FAIL bp_hold_%0d: got v%b rd %0d imm %0d ctrl %h want v1 rd 1 imm 7 ctrl 4800", i, bus.out_valid, bus.out_rd, bus.out_imm, bus.out_ctrl); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3 || bus.out_imm !== 17'd9) begin n_fail++; $display("FAIL bp_second: got v%b rd %0d imm %0d want v1 rd 3 imm 9", bus.out_valid, bus.out_rd, bus.out_imm); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_insn = i_insn(5'b00101, 5'(i), 5'd0, 17'(i * 3));
      tick();
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'(i) || bus.out_imm !== 17'(i * 3))
        begin n_fail++; $display("FAIL b2b_%0d: got v%b rd %0d imm %0d want v1 rd %0d imm %0d", i, bus.out_valid, bus.out_rd, bus.out_imm, i, i * 3); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    send(r_insn(5'd4, 5'd2, 5'd3, 5'b00110));
    tick();
    bus.out_ready = 1'b0;
    send(i_insn(5'b00111, 5'd9, 5'd10, 17'd4));
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 16'h4020) begin n_fail++; $display("FAIL sw_staged: got v%b ctrl %h want v1 ctrl 4020", bus.out_valid, bus.out_ctrl); end
    n_tests++; if ({bus.out_src_a, bus.out_src_b} !== {5'd10, 5'd9}) begin n_fail++; $display("FAIL sw_srcs: got %0d/%0d want 10/9", bus.out_src_a, bus.out_src_b); end
    bus.flush = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy: got %b want 1", bus.md_busy); end
    bus.in_valid = 1'b1;
    bus.in_insn  = r_insn(5'd5, 5'd4, 5'd1, 5'd0);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_sb_kept: got %b want 0", bus.in_ready); end
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.md_wb_valid = 1'b1;
    bus.md_wb_rd    = 5'd4;
    tick();
    bus.md_wb_valid = 1'b0;
    n_tests++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL flush_wb_clear: got %b want 0", bus.md_busy); end
    tick();
  endtask

  task automatic test_async_reset();
    send(r_insn(5'd4, 5'd2, 5'd3, 5'b00111));
    n_tests++; if (bus.out_ctrl !== 16'h8A00) begin n_fail++; $display("FAIL div_ctrl: got %h want 8a00", bus.out_ctrl); end
    tick();
    bus.out_ready = 1'b0;
    send(i_insn(5'b00101, 5'd1, 5'd2, 17'd7));
    n_tests++; if (bus.out_valid !== 1'b1 || bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got v%b busy %b want 1/1", bus.out_valid, bus.md_busy); end
    resetn = 1'b0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_vb: got v%b busy %b want 0/0", bus.out_valid, bus.md_busy); end
    n_tests++; if (bus.out_ctrl !== 16'h0 || bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL async_reset_ctrl: got %h rd %0d want 0000 rd 0", bus.out_ctrl, bus.out_rd); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_in_ready: got %b want 0", bus.in_ready); end
    tick();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_insn     = '0;
    bus.in_pc       = '0;
    bus.out_ready   = 1'b1;
    bus.md_wb_valid = 1'b0;
    bus.md_wb_rd    = '0;
    test_reset();
    tick();
    test_jal();
    test_setx_bex();
    test_r0_write();
    test_multdiv_hazard();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
